// File: rtl/sc_frogger_playfield.sv
// Frogger 8x8 game-state engine: scrolling lanes, frog, collision, score.
// Optional frog blink when SC_FROGGER_PLAYFIELD_FROG_BLINK_EN is defined.
module sc_frogger_playfield #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int PRESCALER_DATAWIDTH = 23,
  parameter logic [PRESCALER_DATAWIDTH-1:0] PRESCALER_TOP = 23'd5000000,
  parameter logic [DATAWIDTH_BUS-1:0] LANE1_INIT = 8'b11000000,
  parameter logic [DATAWIDTH_BUS-1:0] LANE2_INIT = 8'b00011000,
  parameter logic [DATAWIDTH_BUS-1:0] LANE3_INIT = 8'b10000001,
  parameter logic [DATAWIDTH_BUS-1:0] LANE4_INIT = 8'b00110000,
  parameter logic [DATAWIDTH_BUS-1:0] LANE5_INIT = 8'b00000110,
  parameter logic [DATAWIDTH_BUS-1:0] LANE6_INIT = 8'b01100000,
  parameter logic [2:0] FROG_START_COL = 3'd4
`ifdef SC_FROGGER_PLAYFIELD_FROG_BLINK_EN
  , parameter int BLINK_DATAWIDTH = 22
`endif
) (
  input  logic                     SC_FROGGER_PLAYFIELD_CLOCK_50,
  input  logic                     SC_FROGGER_PLAYFIELD_RESET_InHigh,
  input  logic                     SC_FROGGER_PLAYFIELD_Enable_InHigh,
  input  logic                     SC_FROGGER_PLAYFIELD_Restart_InHigh,
  input  logic                     SC_FROGGER_PLAYFIELD_upButton_In,
  input  logic                     SC_FROGGER_PLAYFIELD_leftButton_In,
  input  logic                     SC_FROGGER_PLAYFIELD_rightButton_In,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGGER_PLAYFIELD_row0_Out,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGGER_PLAYFIELD_row1_Out,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGGER_PLAYFIELD_row2_Out,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGGER_PLAYFIELD_row3_Out,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGGER_PLAYFIELD_row4_Out,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGGER_PLAYFIELD_row5_Out,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGGER_PLAYFIELD_row6_Out,
  output logic [DATAWIDTH_BUS-1:0] SC_FROGGER_PLAYFIELD_row7_Out,
  output logic                     SC_FROGGER_PLAYFIELD_EndGame_Out,
  output logic [3:0]               SC_FROGGER_PLAYFIELD_Score_Out
);

  localparam int W = DATAWIDTH_BUS;
  localparam int P = PRESCALER_DATAWIDTH;
  typedef logic [W-1:0] row_t;

  function automatic row_t lane_init(input int i);
    case (i)
      1: return LANE1_INIT;
      2: return LANE2_INIT;
      3: return LANE3_INIT;
      4: return LANE4_INIT;
      5: return LANE5_INIT;
      default: return LANE6_INIT;
    endcase
  endfunction

  function automatic row_t init_row(input int r);
    if (r == 0) return row_t'(1) << FROG_START_COL;
    if (r >= 1 && r <= 6) return lane_init(r);
    return '0;
  endfunction

  row_t       lane_q [1:6];
  row_t       lane_d [1:6];
  row_t       row_q [0:7];
  row_t       row_d [0:7];
  logic [2:0] frow_q, frow_d, fcol_q, fcol_d;
  logic [2:0] btn_q, btn_d, pulse;
  logic [3:0] score_q, score_d, sout_q, sout_d;
  logic [P-1:0] presc_q, presc_d;
  logic       dead_q, dead_d, end_q, end_d;
  logic       active, tick, hit, show;

`ifdef SC_FROGGER_PLAYFIELD_FROG_BLINK_EN
  logic [BLINK_DATAWIDTH-1:0] blink_q, blink_d;
`endif

  always_comb begin
    active  = SC_FROGGER_PLAYFIELD_Enable_InHigh & ~dead_q;
    btn_d   = {SC_FROGGER_PLAYFIELD_upButton_In,
               SC_FROGGER_PLAYFIELD_leftButton_In,
               SC_FROGGER_PLAYFIELD_rightButton_In};
    pulse   = btn_d & ~btn_q;
    tick    = active && (presc_q == PRESCALER_TOP - 1'b1);
    presc_d = presc_q;
    frow_d  = frow_q;
    fcol_d  = fcol_q;
    score_d = score_q;
    for (int i = 1; i <= 6; i++) lane_d[i] = lane_q[i];
    if (active) presc_d = tick ? '0 : presc_q + 1'b1;
    // odd lanes drift toward the MSB, even lanes toward the LSB
    if (tick) begin
      for (int i = 1; i <= 6; i++) begin
        if (i % 2 == 1) lane_d[i] = {lane_q[i][W-2:0], lane_q[i][W-1]};
        else            lane_d[i] = {lane_q[i][0], lane_q[i][W-1:1]};
      end
    end
    if (active) begin
      unique case (1'b1)
        pulse[2]: begin
          if (frow_q == 3'd6) begin
            frow_d  = '0;
            fcol_d  = FROG_START_COL;
            score_d = score_q + 4'd1;
          end else begin
            frow_d = frow_q + 3'd1;
          end
        end
        pulse[1]: if (fcol_q != 3'd7) fcol_d = fcol_q + 3'd1;
        pulse[0]: if (fcol_q != 3'd0) fcol_d = fcol_q - 3'd1;
        default: ;
      endcase
    end
    hit = 1'b0;
    for (int i = 1; i <= 6; i++)
      if (frow_d == 3'(i)) hit = lane_d[i][fcol_d];
    dead_d = dead_q | hit;
`ifdef SC_FROGGER_PLAYFIELD_FROG_BLINK_EN
    blink_d = SC_FROGGER_PLAYFIELD_Enable_InHigh ? blink_q + 1'b1 : blink_q;
    show    = ~blink_q[BLINK_DATAWIDTH-1] | dead_q;
`else
    show    = 1'b1;
`endif
    for (int r = 0; r < 8; r++)
      row_d[r] = (show && frow_q == 3'(r)) ? row_t'(1) << fcol_q : '0;
    for (int i = 1; i <= 6; i++) row_d[i] = row_d[i] | lane_q[i];
    end_d  = dead_q;
    sout_d = score_q;
    if (SC_FROGGER_PLAYFIELD_Restart_InHigh) begin
      for (int i = 1; i <= 6; i++) lane_d[i] = lane_init(i);
      for (int r = 0; r < 8; r++) row_d[r] = init_row(r);
      frow_d  = '0;
      fcol_d  = FROG_START_COL;
      dead_d  = 1'b0;
      score_d = '0;
      presc_d = '0;
      btn_d   = '0;
      end_d   = 1'b0;
      sout_d  = '0;
`ifdef SC_FROGGER_PLAYFIELD_FROG_BLINK_EN
      blink_d = '0;
`endif
    end
  end

  always_ff @(posedge SC_FROGGER_PLAYFIELD_CLOCK_50) begin
    if (SC_FROGGER_PLAYFIELD_RESET_InHigh) begin
      for (int i = 1; i <= 6; i++) lane_q[i] <= lane_init(i);
      for (int r = 0; r < 8; r++) row_q[r] <= init_row(r);
      frow_q  <= '0;
      fcol_q  <= FROG_START_COL;
      dead_q  <= 1'b0;
      score_q <= '0;
      presc_q <= '0;
      btn_q   <= '0;
      end_q   <= 1'b0;
      sout_q  <= '0;
`ifdef SC_FROGGER_PLAYFIELD_FROG_BLINK_EN
      blink_q <= '0;
`endif
    end else begin
      for (int i = 1; i <= 6; i++) lane_q[i] <= lane_d[i];
      for (int r = 0; r < 8; r++) row_q[r] <= row_d[r];
      frow_q  <= frow_d;
      fcol_q  <= fcol_d;
      dead_q  <= dead_d;
      score_q <= score_d;
      presc_q <= presc_d;
      btn_q   <= btn_d;
      end_q   <= end_d;
      sout_q  <= sout_d;
`ifdef SC_FROGGER_PLAYFIELD_FROG_BLINK_EN
      blink_q <= blink_d;
`endif
    end
  end

  assign SC_FROGGER_PLAYFIELD_row0_Out    = row_q[0];
  assign SC_FROGGER_PLAYFIELD_row1_Out    = row_q[1];
  assign SC_FROGGER_PLAYFIELD_row2_Out    = row_q[2];
  assign SC_FROGGER_PLAYFIELD_row3_Out    = row_q[3];
  assign SC_FROGGER_PLAYFIELD_row4_Out    = row_q[4];
  assign SC_FROGGER_PLAYFIELD_row5_Out    = row_q[5];
  assign SC_FROGGER_PLAYFIELD_row6_Out    = row_q[6];
  assign SC_FROGGER_PLAYFIELD_row7_Out    = row_q[7];
  assign SC_FROGGER_PLAYFIELD_EndGame_Out = end_q;
  assign SC_FROGGER_PLAYFIELD_Score_Out   = sout_q;

endmodule

// File: tb/tb_sc_frogger_playfield.sv
// Scoreboard bench for sc_frogger_playfield: a reference game model
// queues expected outputs, DUT samples are queued and matched per task.
module tb_sc_frogger_playfield;

  localparam int TOP = 4;
  localparam logic [7:0] L1 = 8'hC0, L2 = 8'h18, L3 = 8'h01;
  localparam logic [7:0] L4 = 8'h00, L5 = 8'h00, L6 = 8'h00;

  typedef struct packed {
    logic [6:1][7:0] lane;
    logic [2:0] frow;
    logic [2:0] fcol;
    logic dead;
    logic [3:0] score;
    logic [22:0] presc;
    logic pu, pl, pr;
  } m_t;

  typedef struct packed {
    logic [7:0][7:0] row;
    logic eg;
    logic [3:0] sc;
  } o_t;

  logic clk = 1'b0;
  logic rst = 1'b0, en = 1'b0, rs = 1'b0;
  logic up = 1'b0, lf = 1'b0, rt = 1'b0;
  logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic eg;
  logic [3:0] sc;

  int total = 0;
  int bad = 0;
  m_t m;
  o_t last;
  o_t exp_q[$];
  o_t act_q[$];

  always #10 clk = ~clk;

  sc_frogger_playfield #(
    .PRESCALER_TOP(23'd4),
    .LANE1_INIT(L1), .LANE2_INIT(L2), .LANE3_INIT(L3),
    .LANE4_INIT(L4), .LANE5_INIT(L5), .LANE6_INIT(L6)
  ) dut (
    .SC_FROGGER_PLAYFIELD_CLOCK_50(clk),
    .SC_FROGGER_PLAYFIELD_RESET_InHigh(rst),
    .SC_FROGGER_PLAYFIELD_Enable_InHigh(en),
    .SC_FROGGER_PLAYFIELD_Restart_InHigh(rs),
    .SC_FROGGER_PLAYFIELD_upButton_In(up),
    .SC_FROGGER_PLAYFIELD_leftButton_In(lf),
    .SC_FROGGER_PLAYFIELD_rightButton_In(rt),
    .SC_FROGGER_PLAYFIELD_row0_Out(r0),
    .SC_FROGGER_PLAYFIELD_row1_Out(r1),
    .SC_FROGGER_PLAYFIELD_row2_Out(r2),
    .SC_FROGGER_PLAYFIELD_row3_Out(r3),
    .SC_FROGGER_PLAYFIELD_row4_Out(r4),
    .SC_FROGGER_PLAYFIELD_row5_Out(r5),
    .SC_FROGGER_PLAYFIELD_row6_Out(r6),
    .SC_FROGGER_PLAYFIELD_row7_Out(r7),
    .SC_FROGGER_PLAYFIELD_EndGame_Out(eg),
    .SC_FROGGER_PLAYFIELD_Score_Out(sc)
  );

  function automatic m_t minit();
    m_t s;
    s = '0;
    s.lane[1] = L1; s.lane[2] = L2; s.lane[3] = L3;
    s.lane[4] = L4; s.lane[5] = L5; s.lane[6] = L6;
    s.fcol = 3'd4;
    return s;
  endfunction

  function automatic m_t mstep(m_t s, bit e, bit u, bit l, bit r);
    m_t n;
    bit pu, pl, pr;
    logic [7:0] ln;
    n = s;
    pu = u && !s.pu; pl = l && !s.pl; pr = r && !s.pr;
    n.pu = u; n.pl = l; n.pr = r;
    if (e && !s.dead) begin
      if (s.presc == TOP - 1) begin
        n.presc = 0;
        for (int i = 1; i <= 6; i++) begin
          if (i == 1 || i == 3 || i == 5)
            n.lane[i] = (s.lane[i] << 1) | (s.lane[i] >> 7);
          else
            n.lane[i] = (s.lane[i] >> 1) | (s.lane[i] << 7);
        end
      end else begin
        n.presc = s.presc + 1;
      end
      if (pu) begin
        if (s.frow == 6) begin
          n.frow = 0; n.fcol = 4; n.score = s.score + 1;
        end else n.frow = s.frow + 1;
      end else if (pl) begin
        if (s.fcol < 7) n.fcol = s.fcol + 1;
      end else if (pr) begin
        if (s.fcol > 0) n.fcol = s.fcol - 1;
      end
      if (n.frow >= 1 && n.frow <= 6) begin
        ln = n.lane[n.frow];
        if (ln[n.fcol]) n.dead = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic o_t mout(m_t s);
    o_t o;
    logic [7:0] v;
    for (int r = 0; r < 8; r++) begin
      v = 8'h00;
      if (r >= 1 && r <= 6) v = s.lane[r];
      if (s.frow == r) v = v | (8'h01 << s.fcol);
      o.row[r] = v;
    end
    o.eg = s.dead;
    o.sc = s.score;
    return o;
  endfunction

  // pick a move that survives this cycle and leaves a safe follow-up
  function automatic int plan(m_t s);
    int order[4] = '{1, 0, 2, 3};
    m_t s1, s2;
    int a;
    for (int k = 0; k < 4; k++) begin
      a = order[k];
      if ((a == 1 && s.pu) || (a == 2 && s.pl) || (a == 3 && s.pr)) continue;
      s1 = mstep(s, 1, a == 1, a == 2, a == 3);
      if (s1.dead) continue;
      for (int b = 0; b < 4; b++) begin
        s2 = mstep(s1, 1, b == 1, b == 2, b == 3);
        if (!s2.dead) return a;
      end
    end
    return 0;
  endfunction

  task automatic cyc(input bit e, input bit r_st, input bit r_rs,
                     input bit u, input bit l, input bit r);
    o_t x;
    x = (r_st || r_rs) ? mout(minit()) : mout(m);
    m = (r_st || r_rs) ? minit() : mstep(m, e, u, l, r);
    exp_q.push_back(x);
    en = e; rst = r_st; rs = r_rs; up = u; lf = l; rt = r;
    @(posedge clk);
    #1;
    last.row = {r7, r6, r5, r4, r3, r2, r1, r0};
    last.eg = eg;
    last.sc = sc;
    act_q.push_back(last);
  endtask

  task automatic test_reset;
    o_t e, a;
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin bad++; $display("FAIL reset_sb got=%h want=%h", a, e); end
    end
    total++;
    if (last.row[0] !== 8'h10) begin bad++; $display("FAIL reset_row0 got=%h want=10", last.row[0]); end
    total++;
    if (last.row[1] !== 8'hC0) begin bad++; $display("FAIL reset_row1 got=%h want=c0", last.row[1]); end
    total++;
    if (last.row[2] !== 8'h18) begin bad++; $display("FAIL reset_row2 got=%h want=18", last.row[2]); end
    total++;
    if ({last.row[7], last.eg, last.sc} !== 13'h0) begin
      bad++; $display("FAIL reset_r7_eg_sc got=%h/%b/%h want=0", last.row[7], last.eg, last.sc);
    end
    cyc(0, 0, 0, 0, 0, 0);
    exp_q.delete(); act_q.delete();
    cyc(0, 1, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin bad++; $display("FAIL reset_sb2 got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_scroll(input string nm);
    o_t e, a;
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin bad++; $display("FAIL %s_sb got=%h want=%h", nm, a, e); end
    end
    total++;
    if ({last.row[1], last.row[2], last.row[0]} !== 24'h810C10) begin
      bad++; $display("FAIL %s_rows got=%h/%h/%h want=81/0c/10", nm, last.row[1], last.row[2], last.row[0]);
    end
  endtask

  task automatic test_left_right;
    o_t e, a;
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    total++;
    if (last.row[0] !== 8'h20) begin bad++; $display("FAIL held_left got=%h want=20", last.row[0]); end
    for (int k = 0; k < 7; k++) begin cyc(1, 0, 0, 0, 1, 0); cyc(1, 0, 0, 0, 0, 0); end
    total++;
    if (last.row[0] !== 8'h80) begin bad++; $display("FAIL left_sat got=%h want=80", last.row[0]); end
    for (int k = 0; k < 9; k++) begin cyc(1, 0, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 0); end
    total++;
    if (last.row[0] !== 8'h01) begin bad++; $display("FAIL right_sat got=%h want=01", last.row[0]); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin bad++; $display("FAIL move_sb got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_freeze;
    o_t e, a, h;
    h = last;
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 1, 0);
    total++;
    if (last !== h) begin bad++; $display("FAIL freeze_hold got=%h want=%h", last, h); end
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    total++;
    if (last.row[0] !== 8'h01) begin bad++; $display("FAIL freeze_nopulse got=%h want=01", last.row[0]); end
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    total++;
    if (last.row[0] !== 8'h02) begin bad++; $display("FAIL freeze_release got=%h want=02", last.row[0]); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin bad++; $display("FAIL freeze_sb got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_goal;
    o_t e, a;
    int goals = 0;
    int act;
    logic [3:0] old;
    cyc(1, 0, 1, 0, 0, 0);
    for (int k = 0; k < 4000 && goals < 16; k++) begin
      act = plan(m);
      old = m.score;
      cyc(1, 0, 0, act == 1, act == 2, act == 3);
      if (m.score != old) begin
        goals++;
        if (goals == 1 || goals == 16) begin
          cyc(1, 0, 0, 0, 0, 0);
          total++;
          if ({last.sc, last.row[0]} !== {(goals == 1) ? 4'd1 : 4'd0, 8'h10}) begin
            bad++; $display("FAIL goal%0d got=%h/%h want=%0d/10", goals, last.sc, last.row[0], goals % 16);
          end
        end
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); a = act_q.pop_front(); total++;
        if (a !== e) begin bad++; $display("FAIL goal_sb got=%h want=%h", a, e); end
      end
    end
    total++;
    if (goals != 16) begin bad++; $display("FAIL goal_timeout got=%0d want=16", goals); end
  endtask

  task automatic test_collision;
    o_t e, a, h;
    int act;
    cyc(1, 0, 1, 0, 0, 0);
    for (int k = 0; k < 200 && m.frow != 1; k++) begin
      act = plan(m);
      cyc(1, 0, 0, act == 1, act == 2, act == 3);
    end
    for (int k = 0; k < 100 && !m.dead; k++) cyc(1, 0, 0, 0, 0, 0);
    total++;
    if (!m.dead) begin bad++; $display("FAIL hit_timeout got=alive want=dead"); end
    cyc(1, 0, 0, 0, 0, 0);
    total++;
    if (last.eg !== 1'b1) begin bad++; $display("FAIL hit_eg got=%b want=1", last.eg); end
    h = last;
    for (int k = 0; k < 12; k++) cyc(1, 0, 0, k % 3 == 0, k % 3 == 1, k % 3 == 2);
    total++;
    if (last !== h) begin bad++; $display("FAIL dead_hold got=%h want=%h", last, h); end
    cyc(1, 0, 1, 0, 0, 0);
    total++;
    if ({last.eg, last.sc, last.row[0], last.row[1], last.row[7]} !== {1'b0, 4'h0, 24'h10C000}) begin
      bad++; $display("FAIL restart got=%h want=reset", last);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin bad++; $display("FAIL hit_sb got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_same_edge;
    o_t e, a;
    bit fired;
    for (int pass = 0; pass < 2; pass++) begin
      cyc(1, 0, 1, 0, 0, 0);
      fired = 0;
      for (int k = 0; k < 64 && !fired; k++) begin
        if (m.presc == TOP - 1 && m.lane[1] == ((pass == 0) ? 8'h0C : 8'h30)) begin
          cyc(1, 0, 0, 1, 0, 0);
          fired = 1;
        end else cyc(1, 0, 0, 0, 0, 0);
      end
      cyc(1, 0, 0, 0, 0, 0);
      total++;
      if (!fired || {last.eg, last.row[1]} !== ((pass == 0) ? 9'h118 : 9'h070)) begin
        bad++; $display("FAIL same_edge%0d got=%b/%h fired=%0d", pass, last.eg, last.row[1], fired);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin bad++; $display("FAIL same_sb got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_reset_midgame;
    for (int k = 0; k < 6; k++) cyc(1, 0, 0, 0, k == 1, 0);
    cyc(1, 1, 0, 0, 0, 0);
    test_scroll("midrst");
  endtask

  initial begin
    m = minit();
    test_reset;
    test_scroll("scroll");
    test_left_right;
    test_freeze;
    test_goal;
    test_collision;
    test_same_edge;
    test_reset_midgame;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
